// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for the seven-segment scan decoder.
// Carries the snooped segment/anode lines, the clear strobe and the decoded-word handshake.
// Optional decimal point lines are present only when SEG7_DP_EN is defined.
// Ports (modport slave = decoder side):
//   seg_i, an_i, clear_i, word_ready_i, [dp_i]      -> into decoder
//   word_o, word_valid_o, err_mask_o, overrun_o, [dp_o] <- from decoder
interface seg7_scan_decoder_if #(
   parameter int DIGITS = 8
);
   logic [6:0]          seg_i;
   logic [DIGITS-1:0]   an_i;
   logic                clear_i;
   logic                word_ready_i;
   logic [4*DIGITS-1:0] word_o;
   logic                word_valid_o;
   logic [DIGITS-1:0]   err_mask_o;
   logic                overrun_o;
`ifdef SEG7_DP_EN
   logic                dp_i;
   logic [DIGITS-1:0]   dp_o;

   modport slave (
      input  seg_i, an_i, clear_i, word_ready_i, dp_i,
      output word_o, word_valid_o, err_mask_o, overrun_o, dp_o
   );
   modport master (
      output seg_i, an_i, clear_i, word_ready_i, dp_i,
      input  word_o, word_valid_o, err_mask_o, overrun_o, dp_o
   );
`else
   modport slave (
      input  seg_i, an_i, clear_i, word_ready_i,
      output word_o, word_valid_o, err_mask_o, overrun_o
   );
   modport master (
      output seg_i, an_i, clear_i, word_ready_i,
      input  word_o, word_valid_o, err_mask_o, overrun_o
   );
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// Purpose: snoops a multiplexed 7-segment scan, decodes each digit and assembles a full frame word.
// Latency: a digit samples in its SETTLE-th stable cycle; the completed word is valid on the next cycle.
// Backpressure: word_o is held until word_ready_i; a frame completing while word_o is pending is dropped and sets overrun_o.
// Ports: clk, rst_n (async active-low) plus seg7_scan_decoder_if.slave bus
//   (seg_i, an_i, clear_i, word_ready_i -> word_o, word_valid_o, err_mask_o, overrun_o).
// Optional feature macro SEG7_DP_EN: adds dp_i/dp_o, decimal point captured per digit.
module seg7_scan_decoder #(
   parameter int DIGITS = 8,
   parameter int SETTLE = 4
) (
   input  logic clk,
   input  logic rst_n,
   seg7_scan_decoder_if.slave bus
);

   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [6:0]          seg_prev_q;
   logic [DIGITS-1:0]   an_prev_q;
   logic [DIGITS-1:0]   mask_q, mask_d;
   logic [DIGITS-1:0]   perr_q, perr_d;
   logic [4*DIGITS-1:0] pword_q, pword_d;
   logic [4*DIGITS-1:0] word_q, word_d;
   logic [DIGITS-1:0]   err_q, err_d;
   logic                valid_q, valid_d;
   logic                overrun_q, overrun_d;
`ifdef SEG7_DP_EN
   logic                dp_prev_q;
   logic [DIGITS-1:0]   pdp_q, pdp_d;
   logic [DIGITS-1:0]   dp_q, dp_d;
`endif

   logic       legal;
   logic       changed;
   logic       sample;
   logic [4:0] dec;   // {err, nibble}

   // Inverse of the hex encoder table; unknown patterns decode to 0 with err set.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'b1000000: decode = 5'h00;
         7'b1111001: decode = 5'h01;
         7'b0100100: decode = 5'h02;
         7'b0110000: decode = 5'h03;
         7'b0011001: decode = 5'h04;
         7'b0010010: decode = 5'h05;
         7'b0000010: decode = 5'h06;
         7'b1111000: decode = 5'h07;
         7'b0000000: decode = 5'h08;
         7'b0010000: decode = 5'h09;
         7'b0001000: decode = 5'h0A;
         7'b0000011: decode = 5'h0B;
         7'b1000110: decode = 5'h0C;
         7'b0100001: decode = 5'h0D;
         7'b0000110: decode = 5'h0E;
         7'b0001110: decode = 5'h0F;
         default:    decode = 5'h10;
      endcase
   endfunction

   assign dec   = decode(bus.seg_i);
   // Exactly one anode low selects a digit; anything else is a blanking or bus-fight state.
   assign legal = $onehot(~bus.an_i);
`ifdef SEG7_DP_EN
   assign changed = (bus.an_i != an_prev_q) || (bus.seg_i != seg_prev_q) || (bus.dp_i != dp_prev_q);
`else
   assign changed = (bus.an_i != an_prev_q) || (bus.seg_i != seg_prev_q);
`endif

   // Settle counter: cnt is the number of consecutive stable cycles including this one.
   // HOLD suppresses re-sampling until the lines move again.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sample  = 1'b0;
      if (!legal) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (changed || state_q == S_IDLE) begin
         state_d = S_WAIT;
         cnt_d   = ONE_C;
      end else if (state_q == S_WAIT) begin
         cnt_d = cnt_q + ONE_C;
      end
      if (state_d == S_WAIT && cnt_d == SETTLE_C) begin
         sample  = 1'b1;
         state_d = S_HOLD;
      end
   end

   always_comb begin
      mask_d    = mask_q;
      perr_d    = perr_q;
      pword_d   = pword_q;
      word_d    = word_q;
      err_d     = err_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
`ifdef SEG7_DP_EN
      pdp_d     = pdp_q;
      dp_d      = dp_q;
`endif

      if (valid_q && bus.word_ready_i)
         valid_d = 1'b0;

      if (sample) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (!bus.an_i[k]) begin
               pword_d[4*k +: 4] = dec[3:0];
               perr_d[k]         = dec[4];
`ifdef SEG7_DP_EN
               pdp_d[k]          = ~bus.dp_i;
`endif
            end
         end
         mask_d = mask_q | ~bus.an_i;

         // Frame completes in the sampling cycle; the output slot is free if empty or being drained now.
         if (&mask_d) begin
            if (!valid_q || bus.word_ready_i) begin
               word_d  = pword_d;
               err_d   = perr_d;
               valid_d = 1'b1;
`ifdef SEG7_DP_EN
               dp_d    = pdp_d;
`endif
            end else begin
               overrun_d = 1'b1;
            end
            mask_d = '0;
            perr_d = '0;
         end
      end

      // Flush wins over everything; word_o (and dp_o) keep their last value.
      if (bus.clear_i) begin
         mask_d    = '0;
         perr_d    = '0;
         pword_d   = '0;
         valid_d   = 1'b0;
         err_d     = '0;
         overrun_d = 1'b0;
`ifdef SEG7_DP_EN
         pdp_d     = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         seg_prev_q <= '1;
         an_prev_q  <= '1;
         mask_q     <= '0;
         perr_q     <= '0;
         pword_q    <= '0;
         word_q     <= '0;
         err_q      <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef SEG7_DP_EN
         dp_prev_q  <= 1'b1;
         pdp_q      <= '0;
         dp_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         seg_prev_q <= bus.seg_i;
         an_prev_q  <= bus.an_i;
         mask_q     <= mask_d;
         perr_q     <= perr_d;
         pword_q    <= pword_d;
         word_q     <= word_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
`ifdef SEG7_DP_EN
         dp_prev_q  <= bus.dp_i;
         pdp_q      <= pdp_d;
         dp_q       <= dp_d;
`endif
      end
   end

   assign bus.word_o       = word_q;
   assign bus.word_valid_o = valid_q;
   assign bus.err_mask_o   = err_q;
   assign bus.overrun_o    = overrun_q;
`ifdef SEG7_DP_EN
   assign bus.dp_o         = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: scans frames onto the snooped lines and
// checks decoded words against a queue of expected frames.
module tb_seg7_scan_decoder;

   localparam int DIGITS = 8;
   localparam int SETTLE = 4;

   typedef struct packed {
      logic [31:0] word;
      logic [7:0]  err;
      logic [7:0]  dp;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   frames_pushed = 0;
   int   frames_seen = 0;
   exp_t sb[$];
`ifdef SEG7_DP_EN
   int   dp_digit = -1;
`endif

   always #5 clk = ~clk;

   seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

   seg7_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: enc = 7'b1000000;  4'h1: enc = 7'b1111001;
         4'h2: enc = 7'b0100100;  4'h3: enc = 7'b0110000;
         4'h4: enc = 7'b0011001;  4'h5: enc = 7'b0010010;
         4'h6: enc = 7'b0000010;  4'h7: enc = 7'b1111000;
         4'h8: enc = 7'b0000000;  4'h9: enc = 7'b0010000;
         4'hA: enc = 7'b0001000;  4'hB: enc = 7'b0000011;
         4'hC: enc = 7'b1000110;  4'hD: enc = 7'b0100001;
         4'hE: enc = 7'b0000110;  default: enc = 7'b0001110;
      endcase
   endfunction

   // Lines seen by the DUT for exactly n clock edges.
   task automatic show_digit(input int k, input logic [6:0] s, input int n);
      @(posedge clk); #1;
      bus.an_i  = ~(8'b1 << k);
      bus.seg_i = s;
`ifdef SEG7_DP_EN
      bus.dp_i  = (k != dp_digit);
`endif
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      bus.an_i  = '1;
      bus.seg_i = '1;
`ifdef SEG7_DP_EN
      bus.dp_i  = 1'b1;
`endif
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic scan(input logic [31:0] w, input int first, input int last, input int hold);
      for (int k = first; k <= last; k++)
         show_digit(k, enc(w[4*k +: 4]), hold);
   endtask

   task automatic push(input logic [31:0] w, input logic [7:0] e, input logic [7:0] d);
      exp_t x;
      x.word = w; x.err = e; x.dp = d;
      sb.push_back(x);
      frames_pushed++;
   endtask

   // Scoreboard: every accepted word is compared with the oldest expected frame.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.word_valid_o === 1'b1 && bus.word_ready_i === 1'b1) begin
         frames_seen++;
         if (sb.size() == 0) begin
            check("sb_unexpected_frame", 64'(sb.size()), 64'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_word", 64'(bus.word_o), 64'(e.word));
            check("sb_err_mask", 64'(bus.err_mask_o), 64'(e.err));
`ifdef SEG7_DP_EN
            check("sb_dp", 64'(bus.dp_o), 64'(e.dp));
`endif
         end
      end
   end

   initial begin
      rst_n            = 1'b0;
      bus.an_i         = '1;
      bus.seg_i        = '1;
      bus.clear_i      = 1'b0;
      bus.word_ready_i = 1'b1;
`ifdef SEG7_DP_EN
      bus.dp_i         = 1'b1;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_word", 64'(bus.word_o), 64'd0);
      check("rst_valid", 64'(bus.word_valid_o), 64'd0);
      check("rst_err", 64'(bus.err_mask_o), 64'd0);
      check("rst_overrun", 64'(bus.overrun_o), 64'd0);
      rst_n = 1'b1;
      idle(3);

      // 1: basic frame with latency check on the final digit
      push(32'h1234ABCD, 8'h00, 8'h00);
      scan(32'h1234ABCD, 0, 6, 6);
      show_digit(7, enc(4'h1), 1);
      repeat (3) @(posedge clk); #1;
      check("lat_before", 64'(bus.word_valid_o), 64'd0);
      @(posedge clk); #1;
      check("lat_valid", 64'(bus.word_valid_o), 64'd1);
      repeat (2) @(posedge clk);
      idle(4);

      // 2: undecodable pattern on digit 3
      push(32'h00000000, 8'h08, 8'h00);
      for (int k = 0; k < DIGITS; k++)
         show_digit(k, (k == 3) ? 7'b1111111 : enc(4'h0), 6);
      idle(4);

      // 3: digit 5 glitches for SETTLE-1 cycles with a wrong value before the real value
      push(32'h0F1E2D3C, 8'h00, 8'h00);
      scan(32'h0F1E2D3C, 0, 4, 6);
      show_digit(5, enc(4'h8), SETTLE - 1);
      scan(32'h0F1E2D3C, 6, 7, 6);
      idle(4);
      scan(32'h0F1E2D3C, 5, 5, 6);
      idle(4);

      // 4: backpressure and overrun, then clear
      bus.word_ready_i = 1'b0;
      scan(32'h11111111, 0, 7, 6);
      scan(32'h22222222, 0, 7, 6);
      idle(4);
      check("ovr_word", 64'(bus.word_o), 64'h11111111);
      check("ovr_valid", 64'(bus.word_valid_o), 64'd1);
      check("ovr_flag", 64'(bus.overrun_o), 64'd1);
      @(posedge clk); #1; bus.clear_i = 1'b1;
      @(posedge clk); #1; bus.clear_i = 1'b0;
      check("clr_valid", 64'(bus.word_valid_o), 64'd0);
      check("clr_overrun", 64'(bus.overrun_o), 64'd0);
      check("clr_word_kept", 64'(bus.word_o), 64'h11111111);
      bus.word_ready_i = 1'b1;
      idle(3);

      // 5: reset with upper half captured, then a clean frame
      scan(32'h55555555, 4, 7, 6);
      @(posedge clk); #1; rst_n = 1'b0;
      #2;
      check("mid_rst_word", 64'(bus.word_o), 64'd0);
      check("mid_rst_valid", 64'(bus.word_valid_o), 64'd0);
      check("mid_rst_overrun", 64'(bus.overrun_o), 64'd0);
      repeat (2) @(posedge clk); #1; rst_n = 1'b1;
      idle(3);
      push(32'hDEADBEEF, 8'h00, 8'h00);
      scan(32'hDEADBEEF, 0, 7, 6);
      idle(4);

      // 6: two anodes low must not capture; digits 0/1 completed afterwards
      @(posedge clk); #1;
      bus.an_i  = 8'hFC;
      bus.seg_i = enc(4'h8);
      repeat (10) @(posedge clk);
      scan(32'h76543210, 2, 7, 6);
      idle(6);
      check("two_low_no_frame", 64'(bus.word_valid_o), 64'd0);
      push(32'h76543210, 8'h00, 8'h01);
`ifdef SEG7_DP_EN
      dp_digit = 0;
`endif
      scan(32'h76543210, 0, 1, 6);
`ifdef SEG7_DP_EN
      dp_digit = -1;
`endif
      idle(20);

      check("sb_left", 64'(sb.size()), 64'd0);
      check("frame_count", 64'(frames_seen), 64'(frames_pushed));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
